captura_vga: RTL and testbench

CAPTURA_VGA -- requirements
Module: captura_vga

---
 rtl/vga_pkg.sv | 25 ++
 rtl/detector_borda.sv | 21 ++
 rtl/captura_vga.sv | 178 +++++++++++++++++
 tb/tb_captura_vga.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA frame-capture block.
// CAPTURA_VGA_ESPELHO_EN (in captura_vga) selects bottom-up addressing.
package vga_pkg;

  localparam int H_ATIVO_PADRAO = 640;
  localparam int V_ATIVO_PADRAO = 480;
  localparam int END_W = 19;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } pixel_t;

  typedef logic [END_W-1:0] endereco_t;

  typedef enum logic [2:0] {
    OCIOSO,
    ESPERA_QUADRO,
    ESPERA_LINHA,
    CAPTURA,
    FIM
  } estado_t;

endpackage

// File: rtl/detector_borda.sv
// Rise/fall pulse generator for an already-registered 1-bit signal.
// Pulses are combinational and last one cycle.
module detector_borda (
  input  logic clk,
  input  logic rst_n,
  input  logic sinal,
  output logic sobe,
  output logic desce
);

  logic ant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ant <= 1'b0;
    else        ant <= sinal;
  end

  assign sobe  = sinal & ~ant;
  assign desce = ~sinal & ant;

endmodule

// File: rtl/captura_vga.sv
// Captures one VGA frame into a frame buffer, one {B,G,R} word per pixel.
// Define CAPTURA_VGA_ESPELHO_EN for bottom-up (BMP row order) addressing.
module captura_vga
  import vga_pkg::*;
#(
  parameter int H_ATIVO = H_ATIVO_PADRAO,
  parameter int V_ATIVO = V_ATIVO_PADRAO
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Iniciar,
  input  logic        v_sync,
  input  logic        h_sync,
  input  logic        blank,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  output logic        Escrita,
  output logic [18:0] Endereco,
  output logic [23:0] Dado,
  output logic        Ocupado,
  output logic        Concluido,
  output logic        Erro
);

  localparam int CW = $clog2(H_ATIVO + 1);
  localparam int LW = $clog2(V_ATIVO + 1);
  localparam logic [CW-1:0] COL_MAX = CW'(H_ATIVO);
  localparam logic [LW-1:0] LIN_ULT = LW'(V_ATIVO - 1);
  localparam endereco_t PASSO = endereco_t'(H_ATIVO);
`ifdef CAPTURA_VGA_ESPELHO_EN
  localparam endereco_t BASE0 = endereco_t'((V_ATIVO - 1) * H_ATIVO);
`else
  localparam endereco_t BASE0 = '0;
`endif

  estado_t estado, nxt;

  logic   vs_r, hs_r, bl_r;
  pixel_t pix_r;

  logic vs_sobe, vs_desce;
  logic bl_sobe, bl_desce;

  logic [CW-1:0] coluna;
  logic [LW-1:0] linha;
  endereco_t     base;

  logic escreve, avanca, marca_erro, inicia;

  // v_sync rise and h_sync are registered but drive no decision
  logic sinais_unused;
  assign sinais_unused = vs_sobe ^ hs_r;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      vs_r  <= 1'b0;
      hs_r  <= 1'b0;
      bl_r  <= 1'b0;
      pix_r <= '0;
    end else begin
      vs_r  <= v_sync;
      hs_r  <= h_sync;
      bl_r  <= blank;
      pix_r <= '{b: B, g: G, r: R};
    end
  end

  detector_borda u_borda_vs (
    .clk   (Clock),
    .rst_n (Reset),
    .sinal (vs_r),
    .sobe  (vs_sobe),
    .desce (vs_desce)
  );

  detector_borda u_borda_bl (
    .clk   (Clock),
    .rst_n (Reset),
    .sinal (bl_r),
    .sobe  (bl_sobe),
    .desce (bl_desce)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) estado <= OCIOSO;
    else        estado <= nxt;
  end

  always_comb begin
    nxt        = estado;
    escreve    = 1'b0;
    avanca     = 1'b0;
    marca_erro = 1'b0;
    inicia     = 1'b0;
    Ocupado    = 1'b0;
    Concluido  = 1'b0;
    unique case (estado)
      OCIOSO: begin
        if (Iniciar) begin
          inicia = 1'b1;
          nxt    = ESPERA_QUADRO;
        end
      end
      ESPERA_QUADRO: begin
        Ocupado = 1'b1;
        if (vs_desce) nxt = ESPERA_LINHA;
      end
      ESPERA_LINHA: begin
        Ocupado = 1'b1;
        if (vs_desce) begin
          marca_erro = 1'b1;
          nxt        = FIM;
        end else if (bl_sobe) begin
          escreve = 1'b1;
          nxt     = CAPTURA;
        end
      end
      CAPTURA: begin
        Ocupado = 1'b1;
        if (vs_desce) begin
          marca_erro = 1'b1;
          nxt        = FIM;
        end else if (bl_desce) begin
          avanca = 1'b1;
          if (coluna < COL_MAX) marca_erro = 1'b1;
          if (linha == LIN_ULT) nxt = FIM;
          else                  nxt = ESPERA_LINHA;
        end else if (bl_r) begin
          if (coluna < COL_MAX) escreve    = 1'b1;
          else                  marca_erro = 1'b1;
        end
      end
      FIM: begin
        Concluido = 1'b1;
        nxt       = OCIOSO;
      end
      default: nxt = OCIOSO;
    endcase
  end

  // Line base address stepped by one line per row: no multiplier
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Escrita  <= 1'b0;
      Endereco <= '0;
      Dado     <= '0;
      Erro     <= 1'b0;
      coluna   <= '0;
      linha    <= '0;
      base     <= '0;
    end else begin
      Escrita <= escreve;
      if (inicia) begin
        Erro   <= 1'b0;
        coluna <= '0;
        linha  <= '0;
        base   <= BASE0;
      end
      if (marca_erro) Erro <= 1'b1;
      if (escreve) begin
        Endereco <= base + endereco_t'(coluna);
        Dado     <= pix_r;
        coluna   <= coluna + 1'b1;
      end
      if (avanca) begin
        linha  <= linha + 1'b1;
        coluna <= '0;
`ifdef CAPTURA_VGA_ESPELHO_EN
        base   <= base - PASSO;
`else
        base   <= base + PASSO;
`endif
      end
    end
  end

endmodule

// File: tb/tb_captura_vga.sv
// Directed bench for captura_vga on a reduced 8x6 frame.
// Expected addresses follow CAPTURA_VGA_ESPELHO_EN when it is defined.
module tb_captura_vga;

  localparam int H = 8;
  localparam int V = 6;
  localparam int NP = H * V;

`ifdef CAPTURA_VGA_ESPELHO_EN
  localparam int A00 = 40;
  localparam int A57 = 7;
  localparam int A50 = 0;
  localparam int A30 = 16;
  localparam int A20 = 24;
`else
  localparam int A00 = 0;
  localparam int A57 = 47;
  localparam int A50 = 40;
  localparam int A30 = 24;
  localparam int A20 = 16;
`endif

  logic        Clock = 1'b0;
  logic        Reset = 1'b0;
  logic        Iniciar = 1'b0;
  logic        v_sync = 1'b1;
  logic        h_sync = 1'b1;
  logic        blank = 1'b0;
  logic [7:0]  R = 8'h0;
  logic [7:0]  G = 8'h0;
  logic [7:0]  B = 8'h0;
  logic        Escrita;
  logic [18:0] Endereco;
  logic [23:0] Dado;
  logic        Ocupado;
  logic        Concluido;
  logic        Erro;

  int n_chk = 0;
  int n_fail = 0;

  logic [18:0] wr_addr [$];
  logic [23:0] wr_data [$];
  logic [23:0] mem [NP];
  bit          gravado [NP];
  int          n_conc;
  int          oob;
  bit          limpar = 1'b0;

  captura_vga #(.H_ATIVO(H), .V_ATIVO(V)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Iniciar   (Iniciar),
    .v_sync    (v_sync),
    .h_sync    (h_sync),
    .blank     (blank),
    .R         (R),
    .G         (G),
    .B         (B),
    .Escrita   (Escrita),
    .Endereco  (Endereco),
    .Dado      (Dado),
    .Ocupado   (Ocupado),
    .Concluido (Concluido),
    .Erro      (Erro)
  );

  always #5 Clock = ~Clock;

  always @(negedge Clock) begin
    if (limpar) begin
      wr_addr.delete();
      wr_data.delete();
      for (int i = 0; i < NP; i++) begin
        mem[i]     = '0;
        gravado[i] = 1'b0;
      end
      n_conc = 0;
      oob    = 0;
    end else begin
      if (Escrita) begin
        wr_addr.push_back(Endereco);
        wr_data.push_back(Dado);
        if (Endereco < NP) begin
          mem[Endereco]     = Dado;
          gravado[Endereco] = 1'b1;
        end else begin
          oob++;
        end
      end
      if (Concluido) n_conc++;
    end
  end

  function automatic int exp_addr(input int l, input int c);
`ifdef CAPTURA_VGA_ESPELHO_EN
    return (V - 1 - l) * H + c;
`else
    return l * H + c;
`endif
  endfunction

  function automatic logic [23:0] exp_pix(input int l, input int c);
    logic [31:0] lv;
    logic [31:0] cv;
    lv = l;
    cv = c;
    return {lv[7:0], cv[7:0], 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic limpa();
    limpar = 1'b1;
    @(negedge Clock);
    #1 limpar = 1'b0;
  endtask

  task automatic iniciar();
    @(posedge Clock);
    #1 Iniciar = 1'b1;
    @(posedge Clock);
    #1 Iniciar = 1'b0;
  endtask

  task automatic linha(input bit vs, input int vis, input int l,
                       input bit pulso);
    int tot;
    logic [31:0] lv;
    logic [31:0] cv;
    tot = ((vis > H) ? vis : H) + 6;
    lv = l;
    for (int c = 0; c < tot; c++) begin
      @(posedge Clock);
      #1;
      cv = c;
      v_sync  = vs;
      blank   = (c < vis);
      h_sync  = !((c >= tot - 4) && (c < tot - 2));
      R       = 8'h5A;
      G       = (c < vis) ? cv[7:0] : 8'h00;
      B       = lv[7:0];
      Iniciar = pulso && (c == 3);
    end
  endtask

  task automatic bloco_vs();
    linha(1'b0, 0, 0, 1'b0);
    linha(1'b0, 0, 0, 1'b0);
    linha(1'b1, 0, 0, 1'b0);
  endtask

  task automatic quadro(input int sl, input int sn, input int pl);
    bloco_vs();
    for (int l = 0; l < V; l++)
      linha(1'b1, (l == sl) ? sn : H, l, l == pl);
    linha(1'b1, 0, 0, 1'b0);
  endtask

  task automatic verifica(input string tag, input int n_lin,
                          input int sl, input int sn);
    for (int l = 0; l < V; l++) begin
      for (int c = 0; c < H; c++) begin
        bit esp;
        int a;
        esp = (l < n_lin) && !(l == sl && c >= sn && sn < H);
        a = exp_addr(l, c);
        chk({tag, "_grav"}, {31'b0, gravado[a]}, {31'b0, esp});
        if (esp) chk({tag, "_dado"}, {8'b0, mem[a]}, {8'b0, exp_pix(l, c)});
      end
    end
  endtask

  task automatic sequencia(input string tag);
    for (int i = 0; i < wr_addr.size() && i < NP; i++) begin
      chk({tag, "_seq_end"}, {13'b0, wr_addr[i]}, exp_addr(i / H, i % H));
      chk({tag, "_seq_dado"}, {8'b0, wr_data[i]},
          {8'b0, exp_pix(i / H, i % H)});
    end
  endtask

  initial begin
    // reset state
    ciclos(2);
    chk("rst_escrita", {31'b0, Escrita}, 0);
    chk("rst_endereco", {13'b0, Endereco}, 0);
    chk("rst_dado", {8'b0, Dado}, 0);
    chk("rst_ocupado", {31'b0, Ocupado}, 0);
    chk("rst_concluido", {31'b0, Concluido}, 0);
    chk("rst_erro", {31'b0, Erro}, 0);
    Reset = 1'b1;
    ciclos(3);

    // full frame
    limpa();
    iniciar();
    chk("cheio_ocupado", {31'b0, Ocupado}, 1);
    chk("cheio_erro0", {31'b0, Erro}, 0);
    quadro(-1, 0, -1);
    ciclos(3);
    chk("cheio_n_escritas", wr_addr.size(), NP);
    chk("cheio_concluido", n_conc, 1);
    chk("cheio_erro", {31'b0, Erro}, 0);
    chk("cheio_ocupado_fim", {31'b0, Ocupado}, 0);
    chk("cheio_oob", oob, 0);
    if (wr_addr.size() == NP) begin
      chk("cheio_end_l0c0", {13'b0, wr_addr[0]}, A00);
      chk("cheio_end_l5c7", {13'b0, wr_addr[NP-1]}, A57);
      chk("cheio_end_l5c0", {13'b0, wr_addr[40]}, A50);
    end
    sequencia("cheio");
    verifica("cheio", V, -1, H);

    // short line 2 (6 pixels)
    limpa();
    iniciar();
    quadro(2, 6, -1);
    ciclos(3);
    chk("curta_n_escritas", wr_addr.size(), NP - 2);
    chk("curta_erro", {31'b0, Erro}, 1);
    chk("curta_concluido", n_conc, 1);
    chk("curta_l3c0_grav", {31'b0, gravado[A30]}, 1);
    chk("curta_l3c0_dado", {8'b0, mem[A30]}, 32'h03005A);
    verifica("curta", V, 2, 6);
    ciclos(20);
    chk("curta_erro_mantido", {31'b0, Erro}, 1);
    iniciar();
    chk("curta_erro_limpo", {31'b0, Erro}, 0);

    // long line 1 (10 pixels), capture already armed
    limpa();
    quadro(1, 10, -1);
    ciclos(3);
    chk("longa_n_escritas", wr_addr.size(), NP);
    chk("longa_erro", {31'b0, Erro}, 1);
    chk("longa_concluido", n_conc, 1);
    chk("longa_oob", oob, 0);
    chk("longa_l2c0_dado", {8'b0, mem[A20]}, 32'h02005A);
    verifica("longa", V, -1, H);

    // Iniciar pulsed during capture
    limpa();
    iniciar();
    quadro(-1, 0, 3);
    ciclos(3);
    chk("meio_n_escritas", wr_addr.size(), NP);
    chk("meio_concluido", n_conc, 1);
    chk("meio_erro", {31'b0, Erro}, 0);
    sequencia("meio");

    // early v_sync after 4 lines
    limpa();
    iniciar();
    bloco_vs();
    for (int l = 0; l < 4; l++) linha(1'b1, H, l, 1'b0);
    linha(1'b1, 0, 0, 1'b0);
    bloco_vs();
    ciclos(3);
    chk("cedo_erro", {31'b0, Erro}, 1);
    chk("cedo_ocupado", {31'b0, Ocupado}, 0);
    chk("cedo_concluido", n_conc, 1);
    chk("cedo_n_escritas", wr_addr.size(), 32);
    linha(1'b1, H, 4, 1'b0);
    linha(1'b1, H, 5, 1'b0);
    ciclos(3);
    chk("cedo_sem_escritas", wr_addr.size(), 32);
    verifica("cedo", 4, -1, H);

    // reset in the middle of line 2
    limpa();
    iniciar();
    bloco_vs();
    linha(1'b1, H, 0, 1'b0);
    linha(1'b1, H, 1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge Clock);
      #1;
      blank = 1'b1;
      G = 8'(c);
      B = 8'd2;
    end
    #3 Reset = 1'b0;
    #2;
    chk("rmeio_escrita", {31'b0, Escrita}, 0);
    chk("rmeio_endereco", {13'b0, Endereco}, 0);
    chk("rmeio_dado", {8'b0, Dado}, 0);
    chk("rmeio_ocupado", {31'b0, Ocupado}, 0);
    chk("rmeio_concluido", {31'b0, Concluido}, 0);
    chk("rmeio_erro", {31'b0, Erro}, 0);
    @(posedge Clock);
    #1;
    blank = 1'b0;
    Reset = 1'b1;
    ciclos(2);
    limpa();
    quadro(-1, 0, -1);
    ciclos(3);
    chk("rmeio_n_escritas", wr_addr.size(), 0);
    chk("rmeio_n_concluido", n_conc, 0);
    chk("rmeio_ocupado_fim", {31'b0, Ocupado}, 0);
    chk("rmeio_erro_fim", {31'b0, Erro}, 0);
    chk("rmeio_endereco_fim", {13'b0, Endereco}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
